// File: rtl/fp_classify_pipe.sv
// Two-stage IEEE-754 operand classifier: one-hot class + sign, 2-cycle latency, 1 operand/cycle.
// Valid/ready backpressure propagates through both stages; saturating per-class event counters.
module fp_classify_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int CNT_W  = 16,
  localparam int DW    = 1 + EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_sign,
  output logic [5:0]       out_class,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [CNT_W-1:0] cnt_inf,
  output logic [CNT_W-1:0] cnt_nan
);

  localparam logic [5:0] CLS_ZERO = 6'b000001;
  localparam logic [5:0] CLS_SUB  = 6'b000010;
  localparam logic [5:0] CLS_NORM = 6'b000100;
  localparam logic [5:0] CLS_INF  = 6'b001000;
  localparam logic [5:0] CLS_QNAN = 6'b010000;
  localparam logic [5:0] CLS_SNAN = 6'b100000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          expOnes;
    logic          expZero;
    logic          fracZero;
    logic          fracMsb;
  } stageOne_t;

  logic [EXP_W-1:0]  inExp;
  logic [FRAC_W-1:0] inFrac;
  stageOne_t         s1;
  logic              v1;
  logic              load1;
  logic              load2;
  logic              xfer;
  logic [5:0]        cls;

  assign inExp  = in_data[FRAC_W +: EXP_W];
  assign inFrac = in_data[FRAC_W-1:0];

  assign load2    = !out_valid || out_ready;
  assign load1    = !v1 || load2;
  assign in_ready = load1;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1.dat      <= in_data;
        s1.expOnes  <= &inExp;
        s1.expZero  <= ~|inExp;
        s1.fracZero <= ~|inFrac;
        s1.fracMsb  <= inFrac[FRAC_W-1];
      end
    end
  end

  // Priority order matters: zero/sub only when exponent is all-zeros, NaN split by fraction MSB.
  always_comb begin
    cls = CLS_NORM;
    if (s1.expZero && s1.fracZero)      cls = CLS_ZERO;
    else if (s1.expZero)                cls = CLS_SUB;
    else if (s1.expOnes && s1.fracZero) cls = CLS_INF;
    else if (s1.expOnes && s1.fracMsb)  cls = CLS_QNAN;
    else if (s1.expOnes)                cls = CLS_SNAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sign  <= 1'b0;
      out_class <= '0;
    end else if (load2) begin
      out_valid <= v1;
      if (v1) begin
        out_data  <= s1.dat;
        out_sign  <= s1.dat[DW-1];
        out_class <= cls;
      end
    end
  end

  // Clear wins over a same-cycle increment, so that event is intentionally lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_zero <= '0;
      cnt_sub  <= '0;
      cnt_inf  <= '0;
      cnt_nan  <= '0;
    end else if (clr_cnt) begin
      cnt_zero <= '0;
      cnt_sub  <= '0;
      cnt_inf  <= '0;
      cnt_nan  <= '0;
    end else if (xfer) begin
      if (out_class[0] && cnt_zero != CNT_MAX) cnt_zero <= cnt_zero + CNT_ONE;
      if (out_class[1] && cnt_sub  != CNT_MAX) cnt_sub  <= cnt_sub + CNT_ONE;
      if (out_class[3] && cnt_inf  != CNT_MAX) cnt_inf  <= cnt_inf + CNT_ONE;
      if ((out_class[4] || out_class[5]) && cnt_nan != CNT_MAX) cnt_nan <= cnt_nan + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Directed bench: default binary32 build, a CNT_W=2 build and a binary64 build share clock/reset.
module tb_fp_classify_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  // Default build
  logic        aInValid, aInReady, aOutValid, aOutReady, aOutSign, aClr;
  logic [31:0] aInData, aOutData;
  logic [5:0]  aOutClass;
  logic [15:0] aCntZero, aCntSub, aCntInf, aCntNan;

  // Narrow counter build
  logic        bInValid, bInReady, bOutValid, bOutReady, bOutSign, bClr;
  logic [31:0] bInData, bOutData;
  logic [5:0]  bOutClass;
  logic [1:0]  bCntZero, bCntSub, bCntInf, bCntNan;

  // Binary64 build
  logic        cInValid, cInReady, cOutValid, cOutReady, cOutSign, cClr;
  logic [63:0] cInData, cOutData;
  logic [5:0]  cOutClass;
  logic [15:0] cCntZero, cCntSub, cCntInf, cCntNan;

  fp_classify_pipe dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .out_sign(aOutSign), .out_class(aOutClass), .clr_cnt(aClr),
    .cnt_zero(aCntZero), .cnt_sub(aCntSub), .cnt_inf(aCntInf), .cnt_nan(aCntNan)
  );

  fp_classify_pipe #(.CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .out_sign(bOutSign), .out_class(bOutClass), .clr_cnt(bClr),
    .cnt_zero(bCntZero), .cnt_sub(bCntSub), .cnt_inf(bCntInf), .cnt_nan(bCntNan)
  );

  fp_classify_pipe #(.EXP_W(11), .FRAC_W(52)) dutC (
    .clk(clk), .rst_n(rst_n),
    .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
    .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
    .out_sign(cOutSign), .out_class(cOutClass), .clr_cnt(cClr),
    .cnt_zero(cCntZero), .cnt_sub(cCntSub), .cnt_inf(cCntInf), .cnt_nan(cCntNan)
  );

  logic [31:0] tVec [0:6];
  logic [5:0]  tCls [0:6];
  logic        tSgn [0:6];
  logic [31:0] bpVec [0:4];
  logic [63:0] dVec [0:3];
  logic [5:0]  dCls [0:3];
  int          inIdx, outIdx;
  logic        acc, xf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tVec = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h3F800000,
             32'hFF800000, 32'h7FC00000, 32'h7F800001};
    tCls = '{6'b000001, 6'b000001, 6'b000010, 6'b000100,
             6'b001000, 6'b010000, 6'b100000};
    tSgn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bpVec = '{32'h40000000, 32'h00000005, 32'h7F800000, 32'h7FC00001, 32'h00000000};
    dVec = '{64'h7FF0000000000000, 64'h7FF8000000000000,
             64'h0000000000000001, 64'h3FF0000000000000};
    dCls = '{6'b001000, 6'b010000, 6'b000010, 6'b000100};

    aInValid = 0; aOutReady = 1; aClr = 0; aInData = '0;
    bInValid = 0; bOutReady = 1; bClr = 0; bInData = '0;
    cInValid = 0; cOutReady = 1; cClr = 0; cInData = '0;

    // Reset state
    #12;
    check("rst_out_valid", aOutValid, 0);
    check("rst_out_data", aOutData, 0);
    check("rst_out_class", aOutClass, 0);
    check("rst_out_sign", aOutSign, 0);
    check("rst_cnt_zero", aCntZero, 0);
    check("rst_cnt_nan", aCntNan, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    check("rel_in_ready", aInReady, 1);

    // Back-to-back classification, 2-cycle latency
    for (int i = 0; i < 7; i++) begin
      aInData = tVec[i];
      aInValid = 1;
      #1;
      check("t1_in_ready", aInReady, 1);
      tick();
      if (i == 0) begin
        check("t1_latency", aOutValid, 0);
      end else begin
        check("t1_valid", aOutValid, 1);
        check("t1_data", aOutData, tVec[i-1]);
        check("t1_class", aOutClass, tCls[i-1]);
        check("t1_sign", aOutSign, tSgn[i-1]);
      end
    end
    aInValid = 0;
    tick();
    check("t1_valid_last", aOutValid, 1);
    check("t1_data_last", aOutData, tVec[6]);
    check("t1_class_last", aOutClass, tCls[6]);
    tick();
    check("t1_drained", aOutValid, 0);
    check("t1_cnt_zero", aCntZero, 2);
    check("t1_cnt_sub", aCntSub, 1);
    check("t1_cnt_inf", aCntInf, 1);
    check("t1_cnt_nan", aCntNan, 2);

    // Backpressure: two accepted, then stall
    aOutReady = 0;
    aInData = bpVec[0];
    aInValid = 1;
    tick();
    aInData = bpVec[1];
    tick();
    aInData = bpVec[2];
    #1;
    check("t2_in_ready_low", aInReady, 0);
    check("t2_stall_valid", aOutValid, 1);
    check("t2_stall_data", aOutData, bpVec[0]);
    tick();
    tick();
    check("t2_hold_data", aOutData, bpVec[0]);
    check("t2_hold_class", aOutClass, 6'b000100);
    check("t2_hold_in_ready", aInReady, 0);
    inIdx = 2;
    outIdx = 0;
    aOutReady = 1;
    for (int cyc = 0; cyc < 30 && outIdx < 5; cyc++) begin
      aInValid = (inIdx < 5);
      aInData = bpVec[(inIdx < 5) ? inIdx : 0];
      #1;
      acc = aInValid && aInReady;
      xf = aOutValid && aOutReady;
      if (xf) begin
        check("t2_order", aOutData, bpVec[outIdx]);
        outIdx++;
      end
      tick();
      if (acc) inIdx++;
    end
    aInValid = 0;
    check("t2_out_count", outIdx, 5);
    check("t2_in_count", inIdx, 5);
    check("t2_no_dup", aOutValid, 0);

    // Saturation with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      bInData = 32'h7FC00000 | i;
      bInValid = 1;
      tick();
    end
    bInValid = 0;
    tick();
    tick();
    check("t3_sat_nan", bCntNan, 3);
    check("t3_sat_inf", bCntInf, 0);
    bInData = 32'h7F800001;
    bInValid = 1;
    tick();
    bInValid = 0;
    tick();
    check("t3_pre_clr_valid", bOutValid, 1);
    bClr = 1;
    tick();
    bClr = 0;
    check("t3_clr_wins", bCntNan, 0);
    check("t3_clr_xfer", bOutValid, 0);
    bInData = 32'h7FC00000;
    bInValid = 1;
    tick();
    bInValid = 0;
    tick();
    tick();
    check("t3_count_after_clr", bCntNan, 1);

    // Binary64 build
    for (int i = 0; i < 4; i++) begin
      cInData = dVec[i];
      cInValid = 1;
      tick();
      if (i > 0) begin
        check("t4_class", cOutClass, dCls[i-1]);
        check("t4_data", cOutData, dVec[i-1]);
      end
    end
    cInValid = 0;
    tick();
    check("t4_class_last", cOutClass, dCls[3]);
    check("t4_valid_last", cOutValid, 1);

    // Reset with two operands in flight
    aOutReady = 0;
    aInData = 32'h3F800000;
    aInValid = 1;
    tick();
    aInData = 32'h00000000;
    tick();
    aInValid = 0;
    #1;
    check("t5_full_valid", aOutValid, 1);
    check("t5_full_in_ready", aInReady, 0);
    #1;
    rst_n = 0;
    #1;
    check("t5_rst_valid", aOutValid, 0);
    check("t5_rst_cnt_zero", aCntZero, 0);
    check("t5_rst_cnt_nan", aCntNan, 0);
    check("t5_rst_data", aOutData, 0);
    check("t5_rst_class", aOutClass, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("t5_rel_in_ready", aInReady, 1);
    aOutReady = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_stale", aOutValid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
